// File: rtl/switch_input_ctrl.sv
// Board switch/button front end: synchronizes switches, debounces buttons and hands a
// latched switch word to the CPU through a valid/read handshake with a sticky overrun flag.
module switch_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SW_W            = 9,
  parameter int unsigned DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SW_W-1:0]   sw,
  input  logic [2:0]        btn,
  input  logic              rd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              overrun,
  output logic [2:0]        btn_level
);

  localparam logic [15:0] DebLimit = 16'(DEBOUNCE_CYCLES);

  typedef enum logic {StEmpty, StFull} state_e;

  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [2:0]        btn_meta_q, btn_sync_q;
  logic [15:0]       cnt_q [3];
  logic [15:0]       cnt_d [3];
  logic [2:0]        level_q, level_d, level_prev_q;
  logic [2:0]        press;
  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic              overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  // The DEBOUNCE_CYCLES-th consecutive disagreeing cycle flips the level instead of counting.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]   = '0;
      level_d[i] = level_q[i];
      if (btn_sync_q[i] != level_q[i]) begin
        if (cnt_q[i] == DebLimit - 16'd1) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      level_q      <= '0;
      level_prev_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign press = level_q & ~level_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (press[1]) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StEmpty: begin
          if (press[0]) begin
            data_q  <= DATA_W'(sw_sync_q);
            state_q <= StFull;
          end
        end
        StFull: begin
          if (press[0]) begin
            data_q <= DATA_W'(sw_sync_q);
            // A same-cycle read consumed the old word, so nothing was lost.
            if (!rd) begin
              overrun_q <= 1'b1;
            end
          end else if (rd) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = (state_q == StFull);
  assign overrun   = overrun_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Scoreboard bench for switch_input_ctrl: expected {data,valid,overrun} words are queued by
// the stimulus and popped by a monitor whenever the DUT output tuple changes.
module tb_switch_input_ctrl;

  localparam int unsigned Deb = 4;

  logic        clk;
  logic        rst_n;
  logic [8:0]  sw;
  logic [2:0]  btn;
  logic        rd;
  logic [15:0] data;
  logic        valid;
  logic        overrun;
  logic [2:0]  btn_level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] mon_prev;
  logic        mon_en = 1'b0;

  switch_input_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .SW_W(9),
    .DATA_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .btn(btn),
    .rd(rd),
    .data(data),
    .valid(valid),
    .overrun(overrun),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [17:0] cur;
      cur = {data, valid, overrun};
      if (cur !== mon_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got %h expected no change", cur);
        end else begin
          check("scoreboard", 32'(cur), 32'(exp_q.pop_front()));
        end
        mon_prev = cur;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [15:0] d, input logic v, input logic o);
    exp_q.push_back({d, v, o});
  endtask

  // Hold a button for hold ticks, release and let the release debounce settle.
  task automatic press(input int idx, input int hold);
    btn[idx] = 1'b1;
    tick(hold);
    btn[idx] = 1'b0;
    tick(12);
  endtask

  task automatic read_pulse();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    btn   = '0;
    rd    = 1'b0;
    tick(3);
    rst_n = 1'b1;
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid_ovr_lvl", 32'({valid, overrun, btn_level}), 32'h0);
    mon_prev = '0;
    mon_en   = 1'b1;
    tick(2);

    // Basic capture with latency: valid exactly 6 edges after first sample.
    sw = 9'h019;
    tick(3);
    expect_word(16'h0019, 1'b1, 1'b0);
    btn[0] = 1'b1;
    tick(5);
    check("lat_level_E4", 32'(btn_level[0]), 32'h0);
    tick();
    check("lat_level_E5", 32'(btn_level[0]), 32'h1);
    check("lat_valid_E5", 32'(valid), 32'h0);
    tick();
    check("lat_valid_E6", 32'(valid), 32'h1);
    check("lat_data_E6", 32'(data), 32'h0019);
    tick(13);
    btn[0] = 1'b0;
    tick(12);
    expect_word(16'h0019, 1'b0, 1'b0);
    read_pulse();
    check("read_valid", 32'(valid), 32'h0);
    check("read_data", 32'(data), 32'h0019);

    // Glitch rejection: 3-cycle pulse never reaches the debounce limit.
    sw = 9'h0a5;
    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(2);
    check("glitch_level", 32'(btn_level[0]), 32'h0);
    tick(8);
    check("glitch_valid", 32'(valid), 32'h0);
    // Bounce 1/0/1 then a clean press: exactly one capture.
    expect_word(16'h00a5, 1'b1, 1'b0);
    btn[0] = 1'b1;
    tick();
    btn[0] = 1'b0;
    tick();
    press(0, 10);
    expect_word(16'h00a5, 1'b0, 1'b0);
    read_pulse();

    // Overrun and clear via btn[1].
    sw = 9'h008;
    tick(3);
    expect_word(16'h0008, 1'b1, 1'b0);
    press(0, 10);
    sw = 9'h003;
    tick(3);
    expect_word(16'h0003, 1'b1, 1'b1);
    press(0, 10);
    check("ovr_set", 32'({data, valid, overrun}), 32'({16'h0003, 1'b1, 1'b1}));
    expect_word(16'h0003, 1'b1, 1'b0);
    press(1, 10);
    check("ovr_clear", 32'({valid, overrun}), 32'b10);

    // Read on the press cycle while FULL: old word read, new word latched, no overrun.
    sw = 9'h055;
    tick(3);
    expect_word(16'h0055, 1'b1, 1'b0);
    btn[0] = 1'b1;
    tick(6);
    rd = 1'b1;
    check("simul_old_data", 32'(data), 32'h0003);
    tick();
    rd = 1'b0;
    check("simul_new", 32'({data, valid, overrun}), 32'({16'h0055, 1'b1, 1'b0}));
    tick(4);
    btn[0] = 1'b0;
    tick(12);

    // Drain, then a read while EMPTY must change nothing.
    expect_word(16'h0055, 1'b0, 1'b0);
    read_pulse();
    tick(2);
    read_pulse();
    tick(2);
    check("rd_empty", 32'({data, valid, overrun}), 32'({16'h0055, 1'b0, 1'b0}));

    // Long hold yields one capture; re-press yields a second.
    sw = 9'h1ff;
    tick(3);
    expect_word(16'h01ff, 1'b1, 1'b0);
    press(0, 100);
    expect_word(16'h01ff, 1'b0, 1'b0);
    read_pulse();
    sw = 9'h0c3;
    tick(3);
    expect_word(16'h00c3, 1'b1, 1'b0);
    press(0, 10);
    check("repress_data", 32'(data), 32'h00c3);

    // Make outputs nonzero, then reset asynchronously between clock edges.
    sw = 9'h111;
    tick(3);
    expect_word(16'h0111, 1'b1, 1'b1);
    press(0, 10);
    btn[2] = 1'b1;
    tick(8);
    check("status_level", 32'(btn_level), 32'h4);
    expect_word(16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(data), 32'h0);
    check("async_rst_flags", 32'({valid, overrun, btn_level}), 32'h0);
    btn[2] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_idle", 32'({data, valid, overrun, btn_level}), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
